// File: rtl/fir_decimator_if.sv
// Sample/coefficient bus of fir_decimator; dbg_state mirrors the MAC FSM.
// Optional FIR_DECIMATOR_COEFF_READBACK_EN adds the c_re/c_out readback pair.
interface fir_decimator_if #(
  parameter int COEFF_SIZE  = 16,
  parameter int SAMPLE_SIZE = 16,
  parameter int CA_W        = 7
);
  logic                   valid_in;
  logic [SAMPLE_SIZE-1:0] din;
  logic                   valid_out;
  logic [SAMPLE_SIZE-1:0] dout;
  logic                   overrun;
  logic                   c_we;
  logic [COEFF_SIZE-1:0]  c_in;
  logic [CA_W-1:0]        c_addr;
  logic [1:0]             dbg_state;
`ifdef FIR_DECIMATOR_COEFF_READBACK_EN
  logic                   c_re;
  logic [COEFF_SIZE-1:0]  c_out;
`endif

  // valid_in qualifies din for exactly the edge it is high on (no ready:
  // the block always accepts); valid_out is a one-cycle pulse qualifying dout.
  modport master (
    output valid_in, din, c_we, c_in, c_addr,
`ifdef FIR_DECIMATOR_COEFF_READBACK_EN
    output c_re,
    input  c_out,
`endif
    input  valid_out, dout, overrun, dbg_state
  );

  modport slave (
    input  valid_in, din, c_we, c_in, c_addr,
`ifdef FIR_DECIMATOR_COEFF_READBACK_EN
    input  c_re,
    output c_out,
`endif
    output valid_out, dout, overrun, dbg_state
  );
endinterface

// File: rtl/fir_decimator.sv
// Symmetric lowpass FIR decimator by M with one time-multiplexed pre-add MAC.
// Optional coefficient readback port set: FIR_DECIMATOR_COEFF_READBACK_EN.
module fir_decimator #(
  parameter int ORD         = 255,
  parameter int M           = 8,
  parameter int COEFF_SIZE  = 16,
  parameter int SAMPLE_SIZE = 16
) (
  input logic            clk,
  input logic            nrst,
  fir_decimator_if.slave bus
);
  localparam int H     = (ORD + 1) / 2;
  localparam int CAW   = (H > 1) ? $clog2(H) : 1;
  localparam int AW    = $clog2(ORD + 1 + M);
  localparam int BUF   = 1 << AW;
  localparam int FW    = $clog2(ORD + 2);
  localparam int PW    = (M > 1) ? $clog2(M) : 1;
  localparam int PA_W  = SAMPLE_SIZE + 1;
  localparam int PR_W  = PA_W + COEFF_SIZE;
  localparam int ACC_W = SAMPLE_SIZE + COEFF_SIZE + 1 + $clog2(H);

  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (COEFF_SIZE - 2);
  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-SAMPLE_SIZE+1){1'b0}}, {(SAMPLE_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t state_q, state_d;
  logic [CAW-1:0] k_q, k_d;
  logic [1:0]     dc_q, dc_d;

  logic [FW-1:0] fill_q;
  logic [PW-1:0] phase_q;
  logic [AW-1:0] wptr_q, base_q;

  logic [SAMPLE_SIZE-1:0] ram_a [BUF];
  logic [SAMPLE_SIZE-1:0] ram_b [BUF];
  logic [COEFF_SIZE-1:0]  cram  [H];
  logic [SAMPLE_SIZE-1:0] rd_a_q, rd_b_q;
  logic [COEFF_SIZE-1:0]  coef_q;

  logic                    rd_v_q, pa_v_q, mul_v_q;
  logic signed [PA_W-1:0]  pa_q;
  logic signed [COEFF_SIZE-1:0] coef_d_q;
  logic signed [PR_W-1:0]  prod_q;
  logic signed [ACC_W-1:0] acc_q, rnd, shr;
  logic [SAMPLE_SIZE-1:0]  y_sat, dout_q;
  logic                    vout_q, ovr_q;

  logic accept, fill_full, trig, start, issue, emit;
  logic [AW-1:0]  fwd_addr, rev_addr;
  logic [CAW-1:0] c_sel;

  assign accept    = bus.valid_in & ~bus.c_we;
  assign fill_full = (fill_q == FW'(ORD + 1));
  assign trig      = accept & (fill_full ? (phase_q == PW'(M - 1)) : (fill_q == FW'(ORD)));
  assign start     = trig & (state_q == S_IDLE);
  assign issue     = (state_q == S_RUN) & ~bus.c_we;
  assign emit      = (state_q == S_OUT) & ~bus.c_we;

  // RAM A walks back from the newest sample, RAM B forward from the oldest.
  assign fwd_addr = base_q - AW'(k_q);
  assign rev_addr = base_q - AW'(ORD) + AW'(k_q);
  assign c_sel    = (state_q == S_RUN) ? k_q : bus.c_addr;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fill_q  <= '0;
      phase_q <= '0;
      wptr_q  <= '0;
    end else if (accept) begin
      wptr_q <= wptr_q + 1'b1;
      if (!fill_full) fill_q <= fill_q + 1'b1;
      else            phase_q <= (phase_q == PW'(M - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ram_a[wptr_q] <= bus.din;
      ram_b[wptr_q] <= bus.din;
    end
    rd_a_q <= ram_a[fwd_addr];
    rd_b_q <= ram_b[rev_addr];
    if (bus.c_we) cram[bus.c_addr] <= bus.c_in;
    coef_q <= cram[c_sel];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dc_q    <= dc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dc_d    = dc_q;
    case (state_q)
      S_IDLE: if (trig) begin
        state_d = S_RUN;
        k_d     = '0;
      end
      S_RUN: begin
        k_d = k_q + 1'b1;
        if (k_q == CAW'(H - 1)) begin
          state_d = S_DRAIN;
          dc_d    = '0;
        end
      end
      S_DRAIN: begin
        dc_d = dc_q + 1'b1;
        if (dc_q == 2'd2) state_d = S_OUT;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A coefficient load always wins and abandons any computation in flight.
    if (bus.c_we) state_d = S_IDLE;
  end

  assign rnd   = acc_q + RND;
  assign shr   = rnd >>> (COEFF_SIZE - 1);
  assign y_sat = (shr > SMAX) ? SMAX[SAMPLE_SIZE-1:0] :
                 (shr < SMIN) ? SMIN[SAMPLE_SIZE-1:0] : shr[SAMPLE_SIZE-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_v_q   <= 1'b0;
      pa_v_q   <= 1'b0;
      mul_v_q  <= 1'b0;
      pa_q     <= '0;
      coef_d_q <= '0;
      prod_q   <= '0;
      base_q   <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
      vout_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      rd_v_q   <= issue;
      pa_v_q   <= rd_v_q & ~bus.c_we;
      mul_v_q  <= pa_v_q & ~bus.c_we;
      pa_q     <= $signed({rd_a_q[SAMPLE_SIZE-1], rd_a_q}) + $signed({rd_b_q[SAMPLE_SIZE-1], rd_b_q});
      coef_d_q <= $signed(coef_q);
      prod_q   <= pa_q * coef_d_q;
      if (start) begin
        base_q <= wptr_q;
        acc_q  <= '0;
      end else if (mul_v_q) begin
        acc_q <= acc_q + ACC_W'(prod_q);
      end
      vout_q <= emit;
      if (emit) dout_q <= y_sat;
      if (trig && state_q != S_IDLE) ovr_q <= 1'b1;
    end
  end

`ifdef FIR_DECIMATOR_COEFF_READBACK_EN
  logic                  rb_sel_q;
  logic [COEFF_SIZE-1:0] c_hold_q;

  // coef_q carries h[c_addr] the cycle after an accepted read; otherwise hold.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rb_sel_q <= 1'b0;
      c_hold_q <= '0;
    end else begin
      rb_sel_q <= bus.c_re & ~bus.c_we & (state_q == S_IDLE);
      c_hold_q <= bus.c_out;
    end
  end

  assign bus.c_out = rb_sel_q ? coef_q : c_hold_q;
`endif

  assign bus.valid_out = vout_q;
  assign bus.dout      = dout_q;
  assign bus.overrun   = ovr_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator (ORD=15, M=4, 16-bit) against a direct-convolution model.
module tb_fir_decimator;
  localparam int ORD = 15;
  localparam int M   = 4;
  localparam int H   = 8;
  localparam int LAT = H + 4;

  logic clk = 1'b0;
  logic nrst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;

  fir_decimator_if #(.COEFF_SIZE(16), .SAMPLE_SIZE(16), .CA_W(3)) bus ();

  fir_decimator #(.ORD(ORD), .M(M), .COEFF_SIZE(16), .SAMPLE_SIZE(16)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: every accepted sample since reset, the half coefficient set,
  // the edge of the last accepted trigger, and the expected overrun flag.
  int             smp[$];
  int             h[H];
  int             last_t;
  bit             have_last;
  bit             exp_ovr;
  logic [15:0]    exp_q[$];
  int             exp_t_q[$];

  function automatic logic [15:0] ref_y(input int n);
    longint acc = 0;
    for (int j = 0; j <= ORD; j++) begin
      int k;
      k = (j < H) ? j : ORD - j;
      acc += longint'(h[k]) * longint'(smp[n - j]);
    end
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  function automatic void model_reset();
    smp.delete();
    exp_q.delete();
    exp_t_q.delete();
    have_last = 1'b0;
    exp_ovr   = 1'b0;
  endfunction

  // Scoreboard: each valid_out must match the head of exp_q in value and edge.
  always @(negedge clk) begin
    logic [15:0] e;
    int          et;
    if (nrst === 1'b1 && bus.valid_out === 1'b1) begin
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: dout=%h at edge %0d, required no output", bus.dout, cyc);
      end else begin
        e  = exp_q.pop_front();
        et = exp_t_q.pop_front();
        if (bus.dout !== e || cyc !== et) begin
          errors++;
          $display("FAIL output: dout=%h at edge %0d, required %h at edge %0d", bus.dout, cyc, e, et);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    step(2);
    model_reset();
    nrst = 1'b1;
    step(1);
  endtask

  task automatic load_coef(input int k, input logic [15:0] v);
    bus.c_we   = 1'b1;
    bus.c_addr = 3'(k);
    bus.c_in   = v;
    h[k]       = int'($signed(v));
    step(1);
    bus.c_we   = 1'b0;
  endtask

  // Drives one sample now (accepted on the next edge) and returns gap edges later.
  task automatic send(input logic [15:0] v, input int gap);
    int n, t;
    bus.valid_in = 1'b1;
    bus.din      = v;
    smp.push_back(int'($signed(v)));
    n = smp.size() - 1;
    t = cyc + 1;
    if (n >= ORD && ((n - ORD) % M) == 0) begin
      if (!have_last || t >= last_t + LAT + 1) begin
        exp_q.push_back(ref_y(n));
        exp_t_q.push_back(t + LAT);
        last_t    = t;
        have_last = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
    end
    step(1);
    bus.valid_in = 1'b0;
    step(gap - 1);
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      step(1);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d outputs pending, required 0", exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
    step(H + 6);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    step(2);
    checks += 3;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b, required 0", bus.valid_out); end
    if (bus.dout !== 16'h0000)  begin errors++; $display("FAIL reset_dout: got %h, required 0000", bus.dout); end
    if (bus.overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b, required 0", bus.overrun); end
    model_reset();
    nrst = 1'b1;
    step(1);
  endtask

  task automatic test_dc_gain();
    int base;
    do_reset();
    for (int k = 0; k < H; k++) load_coef(k, 16'h0800);
    base = n_out;
    for (int i = 0; i < 40; i++) send(16'h1000, 16);
    wait_drain();
    checks++;
    if (n_out - base != 7) begin errors++; $display("FAIL dc_count: got %0d outputs, required 7", n_out - base); end
    checks++;
    if (bus.dout !== 16'h1000) begin errors++; $display("FAIL dc_value: got %h, required 1000", bus.dout); end
  endtask

  task automatic test_impulse();
    int base;
    do_reset();
    load_coef(0, 16'h7FFF);
    for (int k = 1; k < H; k++) load_coef(k, 16'h0000);
    base = n_out;
    for (int i = 0; i < 28; i++) send((i == 15) ? 16'h4000 : 16'h0000, 5);
    wait_drain();
    checks++;
    if (n_out - base != 4) begin errors++; $display("FAIL impulse_count: got %0d outputs, required 4", n_out - base); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < H; k++) load_coef(k, 16'h7FFF);
    do_reset();
    for (int i = 0; i < 20; i++) send(16'h7FFF, 4);
    wait_drain();
    checks++;
    if (bus.dout !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h, required 7fff", bus.dout); end
    do_reset();
    for (int i = 0; i < 20; i++) send(16'h8000, 4);
    wait_drain();
    checks++;
    if (bus.dout !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h, required 8000", bus.dout); end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int k = 0; k < H; k++) load_coef(k, 16'h0800);
    for (int i = 0; i < 40; i++) begin
      send(16'h1000, 2);
      if (i == 15 || i == 19) begin
        checks++;
        if (bus.overrun !== exp_ovr) begin
          errors++;
          $display("FAIL overrun_after_sample_%0d: got %b, required %b", i, bus.overrun, exp_ovr);
        end
      end
    end
    wait_drain();
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b, required 1", bus.overrun); end
  endtask

  // Trigger spacings of exactly 13 edges (accepted) and 12 edges (dropped).
  task automatic test_back_to_back();
    int gaps[8] = '{3, 3, 3, 4, 3, 3, 3, 3};
    do_reset();
    for (int k = 0; k < H; k++) load_coef(k, 16'($urandom_range(0, 16'h0FFF)));
    for (int i = 0; i < 15; i++) send(16'($urandom_range(0, 16'hFFFF)), 4);
    for (int i = 0; i < 8; i++) send(16'($urandom_range(0, 16'hFFFF)), gaps[i]);
    send(16'($urandom_range(0, 16'hFFFF)), 4);
    wait_drain();
    checks++;
    if (bus.overrun !== exp_ovr || exp_ovr !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overrun: got %b, required 1", bus.overrun);
    end
  endtask

  task automatic test_load_abort();
    int base;
    do_reset();
    for (int k = 0; k < H; k++) load_coef(k, 16'h0800);
    for (int i = 0; i < 15; i++) send(16'h1000, 16);
    send(16'h1000, 1);
    step(4);
    void'(exp_q.pop_back());
    void'(exp_t_q.pop_back());
    have_last = 1'b0;
    base = n_out;
    for (int k = 0; k < H; k++) load_coef(k, 16'h0400);
    step(20);
    checks++;
    if (n_out != base) begin errors++; $display("FAIL abort_no_output: got %0d outputs, required 0", n_out - base); end
    for (int i = 0; i < 4; i++) send(16'h1000, 16);
    wait_drain();
    checks++;
    if (n_out - base != 1 || bus.dout !== 16'h0800) begin
      errors++;
      $display("FAIL abort_reload: got %0d outputs dout=%h, required 1 output dout=0800", n_out - base, bus.dout);
    end
  endtask

  task automatic test_reset_mid_run();
    int base;
    do_reset();
    for (int i = 0; i < 24; i++) send(16'h1000, 2);
    step(1);
    nrst = 1'b0;
    #1;
    checks += 3;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid_out: got %b, required 0", bus.valid_out); end
    if (bus.dout !== 16'h0000)  begin errors++; $display("FAIL midrst_dout: got %h, required 0000", bus.dout); end
    if (bus.overrun !== 1'b0)   begin errors++; $display("FAIL midrst_overrun: got %b, required 0", bus.overrun); end
    model_reset();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    base = n_out;
    for (int i = 0; i < 15; i++) send(16'h1000, 4);
    step(LAT + 4);
    checks++;
    if (n_out != base) begin errors++; $display("FAIL midrst_early: got %0d outputs, required 0", n_out - base); end
    send(16'h1000, 4);
    wait_drain();
    checks++;
    if (n_out - base != 1) begin errors++; $display("FAIL midrst_refill: got %0d outputs, required 1", n_out - base); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < H; k++) load_coef(k, 16'($urandom_range(0, 16'hFFFF)));
    for (int i = 0; i < 60; i++) send(16'($urandom_range(0, 16'hFFFF)), $urandom_range(4, 8));
    wait_drain();
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL random_overrun: got %b, required 0", bus.overrun); end
  endtask

`ifdef FIR_DECIMATOR_COEFF_READBACK_EN
  task automatic test_readback();
    load_coef(3, 16'h1234);
    bus.c_addr = 3'd3;
    bus.c_re   = 1'b1;
    step(1);
    bus.c_re   = 1'b0;
    bus.c_addr = 3'd0;
    checks++;
    if (bus.c_out !== 16'h1234) begin errors++; $display("FAIL readback: got %h, required 1234", bus.c_out); end
    step(2);
    checks++;
    if (bus.c_out !== 16'h1234) begin errors++; $display("FAIL readback_hold: got %h, required 1234", bus.c_out); end
  endtask
`endif

  initial begin
    nrst         = 1'b0;
    bus.valid_in = 1'b0;
    bus.din      = '0;
    bus.c_we     = 1'b0;
    bus.c_in     = '0;
    bus.c_addr   = '0;
`ifdef FIR_DECIMATOR_COEFF_READBACK_EN
    bus.c_re     = 1'b0;
`endif
    model_reset();
    test_reset();
    test_dc_gain();
    test_impulse();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_load_abort();
    test_reset_mid_run();
    test_random();
`ifdef FIR_DECIMATOR_COEFF_READBACK_EN
    test_readback();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
